// File: rtl/i2c_master_byte_tx.sv
// Byte-level I2C transmit sequencer: serialises one byte MSB first into eight
// bit requests, then runs a read-type ACK slot and reports the outcome.
module i2c_master_byte_tx #(
  parameter int unsigned BIT_WATCHDOG = 2047
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] tx_byte,
  output logic       byte_ready,
  input  logic       abort,
  output logic       bit_start,
  output logic       bit_value,
  output logic       bit_is_read,
  input  logic       bit_done,
  input  logic       bit_timeout,
  input  logic       bit_sampled,
  output logic       result_valid,
  output logic       result_ack,
  output logic [1:0] result_error
);

  localparam int unsigned WD_W    = 11;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 3;

  localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(BIT_WATCHDOG);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(BYTE_W - 1);
  localparam logic [1:0]       ERR_NONE   = 2'b00;
  localparam logic [1:0]       ERR_STRETCH = 2'b01;
  localparam logic [1:0]       ERR_WDOG   = 2'b10;
  localparam logic [1:0]       ERR_ABORT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT      = 3'd2,
    S_ACK_ISSUE = 3'd3,
    S_ACK_WAIT  = 3'd4,
    S_REPORT    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic       byte_ready_d;
  logic       bit_start_d;
  logic       bit_value_d;
  logic       bit_is_read_d;
  logic       result_valid_d;
  logic       result_ack_d;
  logic [1:0] result_error_d;
  logic       wd_expired;

  assign wd_expired = (wd_q == WD_LIMIT);

  // State, datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      wd_q         <= '0;
      byte_ready   <= 1'b1;
      bit_start    <= 1'b0;
      bit_value    <= 1'b1;
      bit_is_read  <= 1'b0;
      result_valid <= 1'b0;
      result_ack   <= 1'b0;
      result_error <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      wd_q         <= wd_d;
      byte_ready   <= byte_ready_d;
      bit_start    <= bit_start_d;
      bit_value    <= bit_value_d;
      bit_is_read  <= bit_is_read_d;
      result_valid <= result_valid_d;
      result_ack   <= result_ack_d;
      result_error <= result_error_d;
    end
  end

  // Next-state logic; abort outranks bit_done, which outranks the watchdog
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    wd_d           = wd_q;
    bit_value_d    = bit_value;
    bit_is_read_d  = bit_is_read;
    result_ack_d   = result_ack;
    result_error_d = result_error;

    unique case (state_q)
      S_IDLE: begin
        if (byte_valid) begin
          shift_d        = tx_byte;
          bit_cnt_d      = '0;
          wd_d           = '0;
          result_ack_d   = 1'b0;
          result_error_d = ERR_NONE;
          bit_value_d    = tx_byte[BYTE_W-1];
          bit_is_read_d  = 1'b0;
          state_d        = S_ISSUE;
        end
      end

      S_ISSUE, S_ACK_ISSUE: begin
        wd_d = '0;
        if (abort) begin
          result_error_d = ERR_ABORT;
          result_ack_d   = 1'b0;
          state_d        = S_REPORT;
        end else begin
          state_d = (state_q == S_ISSUE) ? S_WAIT : S_ACK_WAIT;
        end
      end

      S_WAIT, S_ACK_WAIT: begin
        if (abort) begin
          result_error_d = ERR_ABORT;
          result_ack_d   = 1'b0;
          state_d        = S_REPORT;
        end else if (bit_done) begin
          if (bit_timeout) begin
            result_error_d = ERR_STRETCH;
            state_d        = S_REPORT;
          end else if (state_q == S_ACK_WAIT) begin
            result_ack_d = ~bit_sampled;
            state_d      = S_REPORT;
          end else begin
            shift_d = {shift_q[BYTE_W-2:0], 1'b0};
            if (bit_cnt_q == LAST_BIT) begin
              bit_value_d   = 1'b1;
              bit_is_read_d = 1'b1;
              state_d       = S_ACK_ISSUE;
            end else begin
              bit_cnt_d     = bit_cnt_q + CNT_W'(1);
              bit_value_d   = shift_d[BYTE_W-1];
              bit_is_read_d = 1'b0;
              state_d       = S_ISSUE;
            end
          end
        end else if (wd_expired) begin
          result_error_d = ERR_WDOG;
          state_d        = S_REPORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_REPORT: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Moore-style outputs registered from the upcoming state
  always_comb begin
    byte_ready_d   = (state_d == S_IDLE);
    bit_start_d    = (state_d == S_ISSUE) || (state_d == S_ACK_ISSUE);
    result_valid_d = (state_d == S_REPORT);
  end

endmodule

// File: tb/tb_i2c_master_byte_tx.sv
// Randomised scoreboard bench for i2c_master_byte_tx with a transaction-level
// reference model of bit sequence, outcome and latency.
module tb_i2c_master_byte_tx;

  localparam int WD = 5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] tx_byte = '0;
  logic       byte_ready;
  logic       abort = 1'b0;
  logic       bit_start;
  logic       bit_value;
  logic       bit_is_read;
  logic       bit_done = 1'b0;
  logic       bit_timeout = 1'b0;
  logic       bit_sampled = 1'b0;
  logic       result_valid;
  logic       result_ack;
  logic [1:0] result_error;

  i2c_master_byte_tx #(.BIT_WATCHDOG(WD)) dut (
    .clock(clock), .reset_n(reset_n), .byte_valid(byte_valid), .tx_byte(tx_byte),
    .byte_ready(byte_ready), .abort(abort), .bit_start(bit_start),
    .bit_value(bit_value), .bit_is_read(bit_is_read), .bit_done(bit_done),
    .bit_timeout(bit_timeout), .bit_sampled(bit_sampled),
    .result_valid(result_valid), .result_ack(result_ack), .result_error(result_error)
  );

  always #5 clock = ~clock;

  typedef struct { logic ack; logic [1:0] err; int lat; } res_t;
  typedef struct { logic val; logic rd; } bit_t;

  res_t exp_res[$];
  bit_t exp_bits[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic chk_next = 1'b0;
  res_t last;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_byte_ready"},   byte_ready, 1);
    chk({tag, "_bit_start"},    bit_start, 0);
    chk({tag, "_bit_value"},    bit_value, 1);
    chk({tag, "_bit_is_read"},  bit_is_read, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_result_ack"},   result_ack, 0);
    chk({tag, "_result_error"}, result_error, 0);
  endtask

  // Monitor: pops expected bits on bit_start and expected results on result_valid
  always @(negedge clock) begin
    if (reset_n) begin
      if (chk_next) begin
        chk("ready_after_result", byte_ready, 1);
        chk("ack_hold", result_ack, last.ack);
        chk("err_hold", result_error, last.err);
        chk_next = 1'b0;
      end
      if (bit_start) begin
        if (exp_bits.size() == 0) chk("extra_bit_start", 1, 0);
        else begin
          bit_t e;
          e = exp_bits.pop_front();
          chk("bit_value", bit_value, e.val);
          chk("bit_is_read", bit_is_read, e.rd);
        end
      end
      if (result_valid) begin
        if (exp_res.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          last = exp_res.pop_front();
          chk("result_ack", result_ack, last.ack);
          chk("result_error", result_error, last.err);
          chk("result_latency", cyc - acc_cyc, last.lat);
          chk_next = 1'b1;
        end
      end
    end
  end

  task automatic recover();
    reset_n = 1'b0;
    bit_done = 1'b0; bit_timeout = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    exp_bits.delete();
    exp_res.delete();
    chk_next = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // One byte transaction; idx arguments are 0-based bit slots (8 = ACK), -1 = unused
  task automatic send_byte(input logic [7:0] b, input int k, input logic samp,
                           input int to_idx, input int ab_idx, input int sil_idx,
                           input int rst_idx, input bit spur);
    int n, t;
    res_t r;
    bit_t e;
    logic [7:0] sh;

    n = 9; r.ack = ~samp; r.err = 2'b00; r.lat = 9 * (k + 1) + 1;
    if (to_idx >= 0) begin
      n = to_idx + 1; r.ack = 1'b0; r.err = 2'b01; r.lat = n * (k + 1) + 1;
    end else if (ab_idx >= 0) begin
      n = ab_idx + 1; r.ack = 1'b0; r.err = 2'b11; r.lat = n * (k + 1) + 1;
    end else if (sil_idx >= 0) begin
      n = sil_idx + 1; r.ack = 1'b0; r.err = 2'b10; r.lat = 1 + sil_idx * (k + 1) + WD + 2;
    end else if (rst_idx >= 0) begin
      n = rst_idx + 1;
    end
    sh = b;
    for (int i = 0; i < n; i++) begin
      e.val = (i < 8) ? sh[7] : 1'b1;
      e.rd  = (i == 8);
      sh    = {sh[6:0], 1'b0};
      exp_bits.push_back(e);
    end
    if (rst_idx < 0) exp_res.push_back(r);

    chk("ready_before_accept", byte_ready, 1);
    byte_valid = 1'b1; tx_byte = b; acc_cyc = cyc;
    @(negedge clock);
    byte_valid = 1'b0; tx_byte = 8'($urandom);
    chk("ready_low_after_accept", byte_ready, 0);

    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!bit_start && t < 20) begin @(negedge clock); t++; end
      if (!bit_start) begin
        chk("bit_start_wait", 0, 1);
        recover();
        return;
      end
      if (i == rst_idx) begin
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_reset_values("midbyte_reset");
        exp_bits.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        return;
      end
      if (i == sil_idx) break;
      if (spur) begin bit_done = 1'b1; bit_timeout = 1'b1; end
      for (int c = 0; c < k; c++) begin
        @(negedge clock);
        bit_done = 1'b0; bit_timeout = 1'b0;
      end
      bit_done    = 1'b1;
      bit_timeout = (i == to_idx);
      bit_sampled = (i == 8) ? samp : 1'($urandom);
      abort       = (i == ab_idx);
      @(negedge clock);
      bit_done = 1'b0; bit_timeout = 1'b0; abort = 1'b0;
    end

    t = 0;
    while ((exp_res.size() != 0 || chk_next) && t < 40) begin @(negedge clock); t++; end
    chk("result_received", exp_res.size(), 0);
    chk("all_bit_starts_seen", exp_bits.size(), 0);
    if (t >= 40) recover();
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int mode, idx, k;
    bit spur;
    repeat (3) @(negedge clock);
    chk_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clock);

    send_byte(8'hA5, 2, 1'b0, -1, -1, -1, -1, 1'b0);
    send_byte(8'hFF, 2, 1'b1, -1, -1, -1, -1, 1'b0);
    send_byte(8'h3C, 2, 1'b0,  3, -1, -1, -1, 1'b0);
    send_byte(8'h96, 2, 1'b0, -1, -1,  0, -1, 1'b0);
    send_byte(8'h81, 2, 1'b0, -1,  2, -1, -1, 1'b0);
    send_byte(8'h5A, 3, 1'b0, -1, -1, -1,  5, 1'b0);
    send_byte(8'hC3, 6, 1'b0, -1, -1, -1, -1, 1'b0);
    send_byte(8'h42, 1, 1'b0, -1, -1, -1, -1, 1'b1);

    for (int j = 0; j < 40; j++) begin
      mode = $urandom_range(0, 4);
      idx  = $urandom_range(0, 8);
      k    = $urandom_range(1, 6);
      spur = ($urandom_range(0, 3) == 0);
      case (mode)
        1: send_byte(8'($urandom), k, 1'($urandom), idx, -1, -1, -1, spur);
        2: send_byte(8'($urandom), k, 1'($urandom), -1, idx, -1, -1, spur);
        3: send_byte(8'($urandom), k, 1'($urandom), -1, -1, idx, -1, spur);
        default: send_byte(8'($urandom), k, 1'($urandom), -1, -1, -1, -1, spur);
      endcase
    end

    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
